// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_ctrl
//  Description : N-digit multiplexed common-anode seven-segment scanner with
//                DP/blank, leading-zero suppression, PWM dimming, dead time
//                and frame-synchronous double-buffered data.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 250000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    greset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic                    frame_start,
    output logic [7:0]              sseg_cathode,
    output logic [NUM_DIGITS-1:0]   sseg_anode
);

    localparam int c_PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);

    logic [c_PRESC_W-1:0]    r_presc;
    logic [c_IDX_W-1:0]      r_idx;
    logic [BRIGHT_W-1:0]     r_pwm;

    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic                    r_act_lz;
    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_lz;
    logic                    r_pend_valid;

    logic [7:0]              r_cathode;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame_start;

    logic                    w_presc_tc;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_suppress;
    logic                    w_dark;
    logic                    w_pwm_en;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;
    logic [7:0]              w_cathode_nxt;
    logic                    w_frame_start_nxt;

    assign w_presc_tc = (r_presc == c_PRESC_LAST);
    assign w_boundary = w_presc_tc && (r_idx == '0);
    assign w_nibble   = r_act_digits[{r_idx, 2'b00} +: 4];

    // w_upper_zero[i]: this digit and every digit to its left hold zero
    genvar g;
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lz
        assign w_upper_zero[g] = (r_act_digits[4*NUM_DIGITS-1:4*g] == '0);
    end
    assign w_suppress = {w_upper_zero[NUM_DIGITS-1:1] & {(NUM_DIGITS-1){r_act_lz}}, 1'b0};

    assign w_dark   = r_act_blank[r_idx] | w_suppress[r_idx];
    assign w_pwm_en = (brightness == '1) || (r_pwm < brightness);

    always_comb begin
        w_seg = 7'h7F;
        case (w_nibble)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    // The anode stays off on the first cycle of every slot to avoid ghosting
    always_comb begin
        w_anode_nxt = '1;
        if (!w_dark && w_pwm_en && (r_presc != '0)) begin
            w_anode_nxt[r_idx] = 1'b0;
        end
        w_cathode_nxt     = w_dark ? 8'hFF : {~r_act_dp[r_idx], w_seg};
        w_frame_start_nxt = (r_idx == c_IDX_LAST) && (r_presc == '0);
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            r_presc       <= '0;
            r_idx         <= c_IDX_LAST;
            r_pwm         <= '0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '0;
            r_act_lz      <= 1'b0;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_lz     <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_anode       <= '1;
            r_cathode     <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
            if (w_presc_tc) begin
                r_presc <= '0;
                r_idx   <= (r_idx == '0) ? c_IDX_LAST : r_idx - 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // A load landing on the boundary bypasses the pending buffer
            if (w_boundary) begin
                if (load) begin
                    r_act_digits <= digits_in;
                    r_act_dp     <= dp_in;
                    r_act_blank  <= blank_in;
                    r_act_lz     <= lz_suppress;
                end else if (r_pend_valid) begin
                    r_act_digits <= r_pend_digits;
                    r_act_dp     <= r_pend_dp;
                    r_act_blank  <= r_pend_blank;
                    r_act_lz     <= r_pend_lz;
                end
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend_digits <= digits_in;
                r_pend_dp     <= dp_in;
                r_pend_blank  <= blank_in;
                r_pend_lz     <= lz_suppress;
                r_pend_valid  <= 1'b1;
            end

            r_anode       <= w_anode_nxt;
            r_cathode     <= w_cathode_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign frame_start  = r_frame_start;
    assign sseg_cathode = r_cathode;
    assign sseg_anode   = r_anode;

endmodule
`default_nettype wire

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment display controller; successor to the fixed 4-digit scan logic.
- Adds per-digit DP and blank, leading-zero suppression, PWM brightness, one-cycle anti-ghost dead time, and frame-synchronous double-buffered data load.
- Sits between any value producer (BCD counters, hex registers) and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 250000, clk cycles per digit slot (>=4).
- BRIGHT_W, 4, brightness control width.

Ports:
- clk  in  1  system clock.
- greset  in  1  synchronous active-high reset.
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  per-digit decimal point request, 1 = lit.
- blank_in  in  NUM_DIGITS  per-digit force-blank, 1 = dark.
- lz_suppress  in  1  1 = blank leading zeros.
- brightness  in  BRIGHT_W  PWM duty; 0 = off, all-ones = full.
- load  in  1  one-cycle strobe; captures digits_in/dp_in/blank_in/lz_suppress into pending.
- frame_start  out  1  one-cycle pulse at start of each scan frame.
- sseg_cathode  out  8  active-low {dp,g,f,e,d,c,b,a}.
- sseg_anode  out  NUM_DIGITS  active-low digit enables; bit i = digit i.

Behaviour:
- Reset (clk edge with greset=1): prescaler=0, scan index=NUM_DIGITS-1, pwm counter=0, active and pending registers all 0, pending_valid=0, sseg_anode=all 1s, sseg_cathode=8'hFF, frame_start=0. greset overrides load and all counters.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the terminal count, the scan index decrements; index 0 wraps to NUM_DIGITS-1 (frame boundary). Leftmost digit is scanned first.
- Load: a load pulse writes pending and sets pending_valid. A later load before the boundary overwrites pending (last write wins).
- Commit: at a frame boundary with pending_valid=1, pending is copied to active and pending_valid is cleared.
- Load coincident with a boundary: the new inputs commit directly to active and pending_valid stays 0.
- Display never changes mid-frame.
- frame_start: asserted for the cycle in which sseg_anode first shows digit NUM_DIGITS-1 of a new frame. Not asserted during reset.
- Decode (hex -> cathode bits g..a, active low):
  0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  Cathode bit7 = ~dp for the scanned digit.
- Leading-zero suppression (active lz_suppress=1): digit i is suppressed if nibbles NUM_DIGITS-1..i are all 0 and i>0. Digit 0 is never suppressed.
- Blanked digit (blank bit or suppressed): sseg_cathode=8'hFF and its anode bit high. Blank overrides dp.
- PWM: a free-running BRIGHT_W-bit counter increments every clk.
  - brightness = all-ones: the enable is always 1.
  - Otherwise: enable = (pwm_cnt < brightness), so brightness=0 leaves the display dark.
- Anode output:
  - Only the scanned digit's bit can be low.
  - That bit is low only when enable=1, the digit is not blanked, and prescaler != 0 (one-cycle dead time at every slot start).
- Cathode output is driven whenever the digit is selected, independent of PWM and dead time.
- Latency: outputs are registered, one cycle after the prescaler/index/active state that produces them. frame_start is aligned with the outputs.
- Width rules:
  - Prescaler width = clog2(REFRESH_DIV).
  - Index width = clog2(NUM_DIGITS), minimum 1.
  - No arithmetic overflow is possible beyond these wraps.

Test Plan:
- Basic scan and commit (NUM_DIGITS=4, REFRESH_DIV=4, brightness=F): reset, load 16'h12AF with dp_in=0. After the next frame boundary, frame_start pulses and the bench sees:
  - anodes cycle 0111, 1011, 1101, 1110 in order;
  - cathodes F9, A4, 88, 8E, one per slot;
  - anodes all high on the first cycle of each slot.
- Leading-zero suppression: load 16'h0050 with lz_suppress=1 -> digits 3 and 2 fully dark; digit 1 shows 92; digit 0 shows C0. Then load 16'h0000 -> only digit 0 lit, showing C0.
- Blank and DP: blank_in=4'b0100, dp_in=4'b0101 -> digit 2 dark with no dp; digit 0 cathode bit7=0.
- Brightness: brightness=4 -> the active anode is low for exactly 4 of every 16 cycles in a slot (outside the dead cycle). brightness=0 -> anodes stay 4'b1111.
- Double buffer:
  - Two loads mid-frame (1111, then 2222) -> the old value persists to the boundary, then 2222 is shown.
  - A load on the boundary cycle is shown in the same frame.
- Reset mid-frame: assert greset during digit 1 -> the next cycle shows anodes all 1s and cathode FF, active data 0, pending discarded, and scanning restarts at digit 3.
